sobel_stream: RTL
=================

Name: sobel_stream

Overview:
- Streaming, parametrised Sobel edge detector. Consumes one raster-scan pixel per in_valid cycle and produces one filtered pixel per position, with a fixed pipeline latency.
- Holds the two previous image rows in internal line buffers, builds the 3x3 window and computes |gx|+|gy|. Output is either thresholded to black/white or a saturated magnitude.
- Sits between the pixel source (camera/frame buffer read) and the VGA output path in the edge-detection datapath.

Parameters:
- IMG_W, 640, pixels per row (>=4)
- IMG_H, 480, rows per frame (>=3)
- PIX_W, 8, bits per pixel
- MODE, 0, 0 = binary threshold output; 1 = magnitude output saturated to PIX_W bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_pix carries the next raster pixel this cycle
- in_sof  in  1  qualifies in_valid: pixel is (0,0) of a new frame
- in_pix  in  PIX_W  input pixel
- thresh  in  PIX_W+3  magnitude threshold; sampled each cycle, MODE 0 only
- out_valid  out  1  out_pix valid this cycle
- out_pix  out  PIX_W  filtered pixel
- out_sof  out  1  with out_valid: output position (0,0)
- out_eof  out  1  with out_valid: output position (IMG_H-1,IMG_W-1)
- busy  out  1  a frame is in progress (RUN or FLUSH)
- overrun  out  1  sticky error: in_valid asserted while in FLUSH

Behaviour:
- Reset (synchronous, active-high):
  - out_valid, out_pix, out_sof, out_eof, busy and overrun all go to 0; FSM goes to IDLE.
  - Line buffer contents are not reset.
  - A reset mid-frame drops all in-flight pixels; no out_eof is produced for that frame.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN: on in_valid&in_sof. In IDLE, in_valid without in_sof is ignored.
  - RUN -> FLUSH: on acceptance of input position IMG_H*IMG_W-1.
  - FLUSH -> IDLE: once the last flush output has issued into the pipeline.
  - RUN + in_valid&in_sof (mid-frame): abort the current frame. Outputs already in the pipe still drain; no out_eof is produced. Restart RUN with this pixel as position 0.
- Position counters: in_row and in_col advance on each accepted pixel; col wraps at IMG_W-1 and increments row.
- Output position p = input position k-(IMG_W+1). An input at k produces no output while k < IMG_W+1.
- Latency: exactly 3 clk cycles from the accepting in_valid edge to out_valid.
  - Stage 1: line-buffer read and window shift.
  - Stage 2: gx/gy partial sums, shift-add only, no multipliers.
  - Stage 3: magnitude and threshold/saturate.
- Gaps in in_valid are allowed and propagate as gaps in out_valid. There is no backpressure.
- FLUSH: the last IMG_W+1 outputs, position (IMG_H-2,IMG_W-1) and all of row IMG_H-1, are border pixels. They are generated on IMG_W+1 consecutive cycles without input. in_valid in FLUSH is dropped and sets overrun.
  - in_valid&in_sof in FLUSH also sets overrun and does not start a frame.
- Border rule: output is 0 when row==0, row==IMG_H-1, col==0 or col==IMG_W-1. The out-of-image window taps are don't-care.
- Arithmetic:
  - gx = (TR+2MR+BR)-(TL+2ML+BL); gy = (BL+2B+BR)-(TL+2T+TR).
  - mag = |gx|+|gy|, unsigned, PIX_W+3 bits. Max is 8*(2^PIX_W-1), so it never overflows.
  - MODE 0: out_pix = all-ones if mag >= thresh, else 0.
  - MODE 1: out_pix = min(mag, 2^PIX_W-1).
- out_sof and out_eof are asserted only together with out_valid. Exactly IMG_W*IMG_H out_valid pulses are produced per non-aborted frame.
- busy = (state != IDLE) OR any pipeline stage valid.

Optional Feature:
- Macro SOBEL_EDGE_COUNT_EN.
- When defined:
  - Adds output edge_count (ceil(log2(IMG_W*IMG_H+1)) bits) and output edge_count_valid (1 bit).
  - The counter clears at out_sof and counts out_valid cycles with a non-zero out_pix.
  - The final value is latched and edge_count_valid pulses for 1 cycle after out_eof. Both reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg:
  - FSM state enum (IDLE/RUN/FLUSH).
  - Function mag_w(PIX_W) = PIX_W+3.
  - Pipeline latency constant SOBEL_LAT=3.
  - Helper function for the border test.
- Sub-module sobel_line_buffer:
  - Two IMG_W x PIX_W row memories with a single write/read column pointer.
  - Per accepted pixel, outputs the column taps from row-2 and row-1; the current pixel passes through.

Test Plan (IMG_W=8, IMG_H=6 unless stated):
- Flat frame, all pixels 100, MODE 0, thresh=128 -> 48 outputs, all 0; out_sof on the 1st, out_eof on the 48th; busy deasserts after the flush.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 255, MODE 0, thresh=128 -> rows 1-4, cols 3 and 4 = 255 (mag 1020); all other outputs 0.
- Same step with amplitude 10, MODE 1 -> rows 1-4, cols 3,4 = 40; rest 0. Amplitude 100 -> 255 (saturated from 400).
- Input with in_valid toggling 1/0 every cycle -> identical pixel sequence to the gap-free run; each out_valid lands 3 cycles after its enabling input.
- in_sof at input position 20, mid-frame -> no out_eof for the first frame; the second frame yields a full 48-output sequence. in_valid during FLUSH -> overrun=1, held until reset.
- reset pulsed at input position 30 -> next cycle: all outputs 0, state IDLE. A following frame filters correctly.
  - With SOBEL_EDGE_COUNT_EN, the step frame gives edge_count=8.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge detector.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam int unsigned SOBEL_LAT = 3;

   // Per-output control tag travelling alongside the pixel pipeline
   typedef struct packed {
      logic valid;
      logic sof;
      logic eof;
      logic border;
   } tag_t;

   function automatic int unsigned mag_w(input int unsigned pix_w);
      return pix_w + 3;
   endfunction

   function automatic logic is_border(input int unsigned row, input int unsigned col,
                                      input int unsigned img_w, input int unsigned img_h);
      return (row == 0) || (row == img_h - 1) || (col == 0) || (col == img_w - 1);
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two row memories sharing one column pointer; returns the column taps of the
// two previous rows and shifts the incoming pixel into them on each write.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned PIX_W = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(IMG_W)-1:0] col_i,
   input  logic [PIX_W-1:0]         pix_i,
   output logic [PIX_W-1:0]         top_c_o,
   output logic [PIX_W-1:0]         mid_c_o,
   output logic [PIX_W-1:0]         cur_c_o
);

   logic [PIX_W-1:0] top_mem_q [IMG_W];
   logic [PIX_W-1:0] mid_mem_q [IMG_W];

   // Row r-1 moves up to row r-2 as the current pixel takes its slot
   always_ff @(posedge clk) begin
      if (we_i) begin
         mid_mem_q[col_i] <= pix_i;
         top_mem_q[col_i] <= mid_mem_q[col_i];
      end
   end

   assign top_c_o = top_mem_q[col_i];
   assign mid_c_o = mid_mem_q[col_i];
   assign cur_c_o = pix_i;

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |gx|+|gy| filter with threshold or saturated output.
// Optional per-frame edge counter enabled by SOBEL_EDGE_COUNT_EN.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned PIX_W = 8,
   parameter int unsigned MODE  = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [PIX_W-1:0]   in_pix,
   input  logic [PIX_W+2:0]   thresh,
   output logic               out_valid,
   output logic [PIX_W-1:0]   out_pix,
   output logic               out_sof,
   output logic               out_eof,
   output logic               busy,
   output logic               overrun
`ifdef SOBEL_EDGE_COUNT_EN
   ,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count,
   output logic                             edge_count_valid
`endif
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int unsigned MW    = mag_w(PIX_W);
   localparam int unsigned SW    = PIX_W + 2;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
   localparam logic [MW-1:0]    PIX_MAX  = MW'((1 << PIX_W) - 1);

   state_e state_q, state_d;
   logic accept, restart, emit, ovr_set;
   logic [ROW_W-1:0] cur_row, pos_row_q, pos_row_d, orow_q, orow_d;
   logic [COL_W-1:0] cur_col, pos_col_q, pos_col_d, ocol_q, ocol_d;
   tag_t tag_d, s1_q, s2_q;
   logic [PIX_W-1:0] top_c, mid_c, cur_c;
   logic [PIX_W-1:0] win_q [3][3];
   logic [SW-1:0] px_d, nx_d, py_d, ny_d, px_q, nx_q, py_q, ny_q;
   logic [SW-1:0] gx_abs, gy_abs;
   logic [MW-1:0] mag;
   logic [PIX_W-1:0] pix_d;
   logic out_valid_q, out_sof_q, out_eof_q, busy_q, overrun_q;
   logic [PIX_W-1:0] out_pix_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Input acceptance, output emission and state transitions
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      restart = 1'b0;
      emit    = 1'b0;
      ovr_set = 1'b0;
      cur_row = pos_row_q;
      cur_col = pos_col_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_sof) begin
               accept  = 1'b1;
               restart = 1'b1;
               cur_row = '0;
               cur_col = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               accept = 1'b1;
               if (in_sof) begin
                  restart = 1'b1;
                  cur_row = '0;
                  cur_col = '0;
               end
               emit = (cur_row > ROW_W'(1)) || ((cur_row == ROW_W'(1)) && (cur_col != '0));
               if ((cur_row == LAST_ROW) && (cur_col == LAST_COL)) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            emit    = 1'b1;
            ovr_set = in_valid;
            if ((orow_q == LAST_ROW) && (ocol_q == LAST_COL)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Raster position of the next input and of the next emitted output
   always_comb begin
      pos_row_d = pos_row_q;
      pos_col_d = pos_col_q;
      orow_d    = orow_q;
      ocol_d    = ocol_q;
      if (accept) begin
         if (cur_col == LAST_COL) begin
            pos_col_d = '0;
            pos_row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
         end else begin
            pos_col_d = cur_col + COL_W'(1);
            pos_row_d = cur_row;
         end
      end
      if (restart) begin
         orow_d = '0;
         ocol_d = '0;
      end else if (emit) begin
         if (ocol_q == LAST_COL) begin
            ocol_d = '0;
            orow_d = (orow_q == LAST_ROW) ? '0 : orow_q + ROW_W'(1);
         end else begin
            ocol_d = ocol_q + COL_W'(1);
         end
      end
      tag_d.valid  = emit;
      tag_d.sof    = emit && (orow_q == '0) && (ocol_q == '0);
      tag_d.eof    = emit && (orow_q == LAST_ROW) && (ocol_q == LAST_COL);
      tag_d.border = is_border(32'(orow_q), 32'(ocol_q), IMG_W, IMG_H);
   end

   sobel_line_buffer #(
      .IMG_W (IMG_W),
      .PIX_W (PIX_W)
   ) u_line_buffer (
      .clk     (clk),
      .we_i    (accept),
      .col_i   (cur_col),
      .pix_i   (in_pix),
      .top_c_o (top_c),
      .mid_c_o (mid_c),
      .cur_c_o (cur_c)
   );

   // Stage 1: window shift, [row][col] with row 0 the oldest line
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= top_c;
         win_q[1][2] <= mid_c;
         win_q[2][2] <= cur_c;
      end
   end

   // Stage 2: positive/negative partial sums of gx and gy
   always_comb begin
      px_d = SW'(win_q[0][2]) + (SW'(win_q[1][2]) << 1) + SW'(win_q[2][2]);
      nx_d = SW'(win_q[0][0]) + (SW'(win_q[1][0]) << 1) + SW'(win_q[2][0]);
      py_d = SW'(win_q[2][0]) + (SW'(win_q[2][1]) << 1) + SW'(win_q[2][2]);
      ny_d = SW'(win_q[0][0]) + (SW'(win_q[0][1]) << 1) + SW'(win_q[0][2]);
   end

   always_ff @(posedge clk) begin
      px_q <= px_d;
      nx_q <= nx_d;
      py_q <= py_d;
      ny_q <= ny_d;
   end

   // Stage 3: magnitude, then threshold or saturate; borders forced to zero
   always_comb begin
      gx_abs = (px_q >= nx_q) ? (px_q - nx_q) : (nx_q - px_q);
      gy_abs = (py_q >= ny_q) ? (py_q - ny_q) : (ny_q - py_q);
      mag    = MW'(gx_abs) + MW'(gy_abs);
      pix_d  = '0;
      if (!s2_q.border) begin
         if (MODE == 0) pix_d = (mag >= thresh) ? '1 : '0;
         else           pix_d = (mag > PIX_MAX) ? '1 : PIX_W'(mag);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_row_q   <= '0;
         pos_col_q   <= '0;
         orow_q      <= '0;
         ocol_q      <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pos_row_q   <= pos_row_d;
         pos_col_q   <= pos_col_d;
         orow_q      <= orow_d;
         ocol_q      <= ocol_d;
         s1_q        <= tag_d;
         s2_q        <= s1_q;
         out_valid_q <= s2_q.valid;
         out_pix_q   <= s2_q.valid ? pix_d : '0;
         out_sof_q   <= s2_q.sof;
         out_eof_q   <= s2_q.eof;
         busy_q      <= (state_d != ST_IDLE) || emit || s1_q.valid || s2_q.valid;
         overrun_q   <= overrun_q || ovr_set;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

`ifdef SOBEL_EDGE_COUNT_EN
   localparam int unsigned ECW = $clog2(IMG_W*IMG_H+1);

   logic [ECW-1:0] ecnt_q, ecnt_d, edge_count_q;
   logic           edge_count_valid_q;

   always_comb begin
      ecnt_d = (out_sof_q ? '0 : ecnt_q) + ECW'(|out_pix_q);
   end

   // Running non-zero count, latched on the last output of the frame
   always_ff @(posedge clk) begin
      if (reset) begin
         ecnt_q             <= '0;
         edge_count_q       <= '0;
         edge_count_valid_q <= 1'b0;
      end else begin
         edge_count_valid_q <= 1'b0;
         if (out_valid_q) begin
            ecnt_q <= ecnt_d;
            if (out_eof_q) begin
               edge_count_q       <= ecnt_d;
               edge_count_valid_q <= 1'b1;
            end
         end
      end
   end

   assign edge_count       = edge_count_q;
   assign edge_count_valid = edge_count_valid_q;
`endif

endmodule
